alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 218 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered N-bit ALU with a valid/ready handshake on both sides.
//
// Single-cycle operations load their result on the acceptance edge, so the
// result is valid one cycle after acceptance. Unsigned divide and modulo use a
// restoring shift-subtract divider that produces one quotient bit per cycle.
// That result is valid N+1 cycles after acceptance.
//
// Parameters
//   N          operand / result width in bits (2..32)
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   request valid
//   in_ready   block can accept a request this cycle
//   a, b       operands (N bits)
//   select     opcode (4 bits)
//   out        registered result (N bits)
//   flags      registered flags {Z, Nf, C, V, DZ}
//   out_valid  out / flags hold a result not yet taken
//   out_ready  consumer takes the result this cycle
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   select,
  output logic [N-1:0] out,
  output logic [4:0]   flags,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int             CW       = $clog2(N) + 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(N);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_SRL = 4'h5,
    OP_SRA = 4'h6,
    OP_SLL = 4'h7,
    OP_MUL = 4'h8,
    OP_DIV = 4'h9,
    OP_MOD = 4'hA
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_DIV
  } state_e;

  // Registered state
  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_out;
  logic [4:0]    r_flags;
  logic          r_out_valid;
  logic [N-1:0]  r_rem;      // partial remainder
  logic [N-1:0]  r_quo;      // dividend shifting out / quotient shifting in
  logic [N-1:0]  r_dvs;      // divisor
  logic          r_is_mod;

  // Combinational single-cycle datapath
  logic [N:0]    w_sum;
  logic [N-1:0]  w_diff;
  logic [2*N-1:0] w_prod;
  logic          w_add_ovf;
  logic          w_sub_ovf;
  logic          w_shift_big;
  logic [N-1:0]  w_res;
  logic          w_c;
  logic          w_v;
  logic          w_dz;
  logic          w_start_div;
  logic [4:0]    w_flags;
  logic          w_accept;

  // Divider step
  logic [N:0]    w_rem_sh;
  logic [N:0]    w_trial;
  logic          w_ge;
  logic [N-1:0]  w_rem_nxt;
  logic [N-1:0]  w_quo_nxt;
  logic [N-1:0]  w_div_res;

  assign w_sum       = {1'b0, a} + {1'b0, b};
  assign w_diff      = a - b;
  assign w_prod      = {{N{1'b0}}, a} * {{N{1'b0}}, b};
  assign w_add_ovf   = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
  assign w_sub_ovf   = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
  assign w_shift_big = (32'(b) >= 32'(N));

  // A new request is taken only when idle and the output register is free
  // or being emptied on this same edge; reset blocks acceptance outright.
  assign in_ready = !rst && (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // NOTE: every output of this block gets a value before the case statement,
  //       so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_res       = w_sum[N-1:0];
    w_c         = 1'b0;
    w_v         = 1'b0;
    w_dz        = 1'b0;
    w_start_div = 1'b0;
    case (select)
      OP_SUB: begin
        w_res = w_diff;
        w_c   = (a < b);
        w_v   = w_sub_ovf;
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SRL: w_res = w_shift_big ? '0 : (a >> b);
      OP_SRA: w_res = w_shift_big ? {N{a[N-1]}} : $unsigned($signed(a) >>> b);
      OP_SLL: w_res = w_shift_big ? '0 : (a << b);
      OP_MUL: begin
        w_res = w_prod[N-1:0];
        w_v   = |w_prod[2*N-1:N];
      end
      OP_DIV, OP_MOD: begin
        if (b == '0) begin
          // Divide by zero completes at once: quotient all-ones, remainder a.
          w_res = (select == OP_MOD) ? a : '1;
          w_dz  = 1'b1;
        end else begin
          w_res       = '0;
          w_start_div = 1'b1;
        end
      end
      // 0000 and the unused opcodes 1011..1111 all perform add.
      default: begin
        w_res = w_sum[N-1:0];
        w_c   = w_sum[N];
        w_v   = w_add_ovf;
      end
    endcase
  end

  assign w_flags = {(w_res == '0), w_res[N-1], w_c, w_v, w_dz};

  // Restoring step: shift the next dividend bit into the remainder and keep
  // the subtraction only when it does not go negative.
  assign w_rem_sh  = {r_rem, r_quo[N-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_dvs};
  assign w_ge      = !w_trial[N];
  assign w_rem_nxt = w_ge ? w_trial[N-1:0] : w_rem_sh[N-1:0];
  assign w_quo_nxt = {r_quo[N-2:0], w_ge};
  assign w_div_res = r_is_mod ? w_rem_nxt : w_quo_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out       <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_is_mod    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments; the clear below is overridden by a
      //       later load in this block on the same edge, which is what gives
      //       bubble-free back-to-back results.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_start_div) begin
              r_state  <= S_DIV;
              r_cnt    <= CNT_LOAD;
              r_rem    <= '0;
              r_quo    <= a;
              r_dvs    <= b;
              r_is_mod <= (select == OP_MOD);
            end else begin
              r_out       <= w_res;
              r_flags     <= w_flags;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state     <= S_IDLE;
            r_out       <= w_div_res;
            r_flags     <= {(w_div_res == '0), w_div_res[N-1], 3'b000};
            r_out_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out       = r_out;
  assign flags     = r_flags;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed bench for alu_seq. Two instances share clock and
// reset: one with N=4 for the single-cycle operations and back-pressure, one
// with N=8 for the multi-cycle divider and the mid-division reset.
// Inputs change and outputs are read 2 time units after each rising edge.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  logic clk;
  logic rst;

  // N=4 instance
  logic       iv4, ir4, ov4, ordy4;
  logic [3:0] a4, b4, sel4, out4;
  logic [4:0] fl4;

  // N=8 instance
  logic       iv8, ir8, ov8, ordy8;
  logic [7:0] a8, b8, out8;
  logic [3:0] sel8;
  logic [4:0] fl8;

  int checks = 0;
  int errors = 0;

  alu_seq #(.N(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .a         (a4),
    .b         (b4),
    .select    (sel4),
    .out       (out4),
    .flags     (fl4),
    .out_valid (ov4),
    .out_ready (ordy4)
  );

  alu_seq #(.N(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .a         (a8),
    .b         (b8),
    .select    (sel8),
    .out       (out8),
    .flags     (fl8),
    .out_valid (ov8),
    .out_ready (ordy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one request to the N=4 instance for exactly one edge.
  task automatic op4(input logic [3:0] a_i, input logic [3:0] b_i, input logic [3:0] s_i);
    iv4  = 1'b1;
    a4   = a_i;
    b4   = b_i;
    sel4 = s_i;
    tick();
    iv4  = 1'b0;
  endtask

  task automatic op8(input logic [7:0] a_i, input logic [7:0] b_i, input logic [3:0] s_i);
    iv8  = 1'b1;
    a8   = a_i;
    b8   = b_i;
    sel8 = s_i;
    tick();
    iv8  = 1'b0;
  endtask

  task automatic res4(input string tag, input logic [3:0] exp_out, input logic [4:0] exp_fl);
    check({tag, " valid"}, ov4, 1);
    check({tag, " out"}, out4, exp_out);
    check({tag, " flags"}, fl4, exp_fl);
  endtask

  task automatic res8(input string tag, input logic [7:0] exp_out, input logic [4:0] exp_fl);
    check({tag, " valid"}, ov8, 1);
    check({tag, " out"}, out8, exp_out);
    check({tag, " flags"}, fl8, exp_fl);
  endtask

  initial begin
    // Reset, with a request on the N=4 side that must be dropped.
    rst   = 1'b1;
    iv4   = 1'b1;  a4 = 4'd1;  b4 = 4'd1;  sel4 = 4'b0000;  ordy4 = 1'b1;
    iv8   = 1'b0;  a8 = 8'd0;  b8 = 8'd0;  sel8 = 4'b0000;  ordy8 = 1'b1;
    tick();
    check("rst ov4", ov4, 0);
    check("rst out4", out4, 0);
    check("rst fl4", fl4, 0);
    check("rst ir4", ir4, 0);
    check("rst ov8", ov8, 0);
    check("rst ir8", ir8, 0);
    rst = 1'b0;
    iv4 = 1'b0;
    #1;
    check("post-rst ir4", ir4, 1);
    check("post-rst ir8", ir8, 1);
    check("dropped req ov4", ov4, 0);

    // Single-cycle operations, N=4, out_ready=1. flags = {Z,Nf,C,V,DZ}.
    op4(4'd7, 4'd9, 4'b0000);       res4("add 7+9", 4'b0000, 5'b10100);
    op4(4'd3, 4'd5, 4'b0001);       res4("sub 3-5", 4'b1110, 5'b01100);
    op4(4'b1000, 4'd2, 4'b0110);    res4("sra 8>>>2", 4'b1110, 5'b01000);
    op4(4'b1000, 4'd5, 4'b0110);    res4("sra b>=N", 4'b1111, 5'b01000);
    op4(4'b1111, 4'd4, 4'b0101);    res4("srl b=N", 4'b0000, 5'b10000);
    op4(4'b0011, 4'd1, 4'b0111);    res4("sll", 4'b0110, 5'b00000);
    op4(4'b1100, 4'b1010, 4'b0010); res4("and", 4'b1000, 5'b01000);
    op4(4'b1100, 4'b1010, 4'b0100); res4("xor", 4'b0110, 5'b00000);
    op4(4'd5, 4'd3, 4'b1000);       res4("mul 5*3", 4'b1111, 5'b01000);
    op4(4'd6, 4'd3, 4'b1000);       res4("mul 6*3", 4'b0010, 5'b00010);
    op4(4'd2, 4'd3, 4'b1011);       res4("op 1011 add", 4'b0101, 5'b00000);
    op4(4'd8, 4'd8, 4'b1111);       res4("op 1111 add", 4'b0000, 5'b10110);
    op4(4'd5, 4'd0, 4'b1001);       res4("div by 0", 4'b1111, 5'b01001);
    op4(4'd5, 4'd0, 4'b1010);       res4("mod by 0", 4'b0101, 5'b00001);

    // Back-pressure: result held for 3 cycles, then taken together with a new request.
    op4(4'd1, 4'd2, 4'b0000);       res4("bp add", 4'd3, 5'b00000);
    ordy4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp hold %0d valid", i), ov4, 1);
      check($sformatf("bp hold %0d out", i), out4, 4'd3);
      check($sformatf("bp hold %0d flags", i), fl4, 5'b00000);
      check($sformatf("bp hold %0d ir", i), ir4, 0);
    end
    ordy4 = 1'b1;
    iv4 = 1'b1;  a4 = 4'd4;  b4 = 4'd4;  sel4 = 4'b0000;
    #1;
    check("bp release ir", ir4, 1);
    tick();
    iv4 = 1'b0;
    res4("bp next add", 4'b1000, 5'b01010);
    tick();
    check("bp drained valid", ov4, 0);

    // N=8 add with carry.
    op8(8'd200, 8'd100, 4'b0000);   res8("add8 carry", 8'h2C, 5'b00100);

    // N=8 divide 200/7 while a junk request is held on in_valid.
    iv8 = 1'b1;  a8 = 8'd200;  b8 = 8'd7;  sel8 = 4'b1001;
    #1;
    check("div accept ir", ir8, 1);
    tick();
    a8 = 8'd1;  b8 = 8'd1;  sel8 = 4'b0000;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("div busy %0d ir", i), ir8, 0);
      check($sformatf("div busy %0d ov", i), ov8, 0);
      if (i == 8) iv8 = 1'b0;
      tick();
    end
    res8("div 200/7", 8'd28, 5'b00000);
    check("div done ir", ir8, 1);

    // Modulo, accepted in the same cycle the quotient is taken.
    op8(8'd200, 8'd7, 4'b1010);
    check("mod start ov", ov8, 0);
    for (int i = 2; i <= 8; i++) begin
      check($sformatf("mod busy %0d ir", i), ir8, 0);
      tick();
    end
    check("mod last-iter ov", ov8, 0);
    tick();
    res8("mod 200%7", 8'd4, 5'b00000);

    // Reset at iteration 4 of a divide aborts it with no result.
    op8(8'd200, 8'd7, 4'b1001);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort ov", ov8, 0);
    check("abort out", out8, 0);
    check("abort flags", fl8, 0);
    check("abort ir", ir8, 0);
    rst = 1'b0;
    #1;
    check("abort release ir", ir8, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("abort no result %0d", i), ov8, 0);
    end
    op8(8'd100, 8'd27, 4'b0000);    res8("add after abort", 8'd127, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
